// File: rtl/dct8_mac_engine.sv
// dct8_mac_engine: 8-point DCT-II computed sequentially with one external multiplier and a saturating accumulator.
// Define DCT_LEVEL_SHIFT_EN to store each sample as in_data-128 (JPEG level shift).
module dct8_mac_engine #(
  parameter int IN_W    = 32,
  parameter int CONST_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [IN_W-1:0]    in_data,
  output logic signed [IN_W-1:0]    mul_a,
  output logic signed [CONST_W-1:0] mul_b,
  input  logic signed [IN_W-1:0]    mul_p,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [IN_W-1:0]    out_data,
  output logic [2:0]                out_index
);
  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;
  state_t state, state_nx;
  logic [2:0] n, k;
  logic live, take;
  logic signed [IN_W-1:0] x [8];
  logic signed [IN_W-1:0] sample, sat;
  logic signed [IN_W+2:0] acc;
  logic signed [CONST_W-1:0] rom [64];
  // Cosine table in Q15 (32767 full scale), folded by symmetry from the angle index m = (2n+1)k mod 32.
  function automatic int coef_q15(int kk, int nn);
    int m, c;
    bit neg;
    m = ((2 * nn + 1) * kk) % 32;
    m = (m > 16) ? 32 - m : m;
    neg = m > 8;
    m = neg ? 16 - m : m;
    case (m)
      1: c = 16069;
      2: c = 15136;
      3: c = 13622;
      4: c = 11585;
      5: c = 9102;
      6: c = 6270;
      7: c = 3196;
      default: c = 0;
    endcase
    return (kk == 0) ? 11585 : (neg ? -c : c);
  endfunction
  function automatic longint scale(int v);
    return (longint'(v) * ((longint'(1) <<< (CONST_W - 1)) - longint'(1)) +
            (v < 0 ? -longint'(16383) : longint'(16383))) / longint'(32767);
  endfunction
  for (genvar i = 0; i < 64; i++) begin : g_rom
    localparam logic signed [CONST_W-1:0] C = CONST_W'(scale(coef_q15(i / 8, i % 8)));
    assign rom[i] = C;
  end
`ifdef DCT_LEVEL_SHIFT_EN
  assign sample = in_data - IN_W'(128);
`else
  assign sample = in_data;
`endif
  assign take = in_valid && in_ready;
  assign sat = (&acc[IN_W+2:IN_W-1] || ~|acc[IN_W+2:IN_W-1]) ? acc[IN_W-1:0]
             : {acc[IN_W+2], {(IN_W-1){~acc[IN_W+2]}}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOAD;
    else state <= state_nx;
  always_comb
    state_nx = (state == LOAD) ? ((take && n == 3'd7) ? CALC : LOAD)
             : (state == CALC) ? ((n == 3'd7) ? OUT : CALC)
             : out_ready ? ((k == 3'd7) ? LOAD : CALC) : OUT;
  always_comb begin
    in_ready  = state == LOAD && live;
    mul_a     = (state == CALC) ? x[n] : '0;
    mul_b     = (state == CALC) ? rom[{k, n}] : '0;
    out_valid = state == OUT;
    out_data  = (state == OUT) ? sat : '0;
    out_index = (state == OUT) ? k : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n    <= '0;
      k    <= '0;
      acc  <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (state == LOAD && take) n <= n + 3'd1;
      if (state == CALC) begin
        n   <= n + 3'd1;
        acc <= ((n == 3'd0) ? '0 : acc) + {{3{mul_p[IN_W-1]}}, mul_p};
      end
      if (state == OUT && out_ready) k <= k + 3'd1;
    end
  always_ff @(posedge clk)
    if (state == LOAD && take) x[n] <= sample;
endmodule

// File: tb/tb_dct8_mac_engine.sv
// tb_dct8_mac_engine: directed scoreboard bench for dct8_mac_engine with an ideal fixed-point multiplier.
module tb_dct8_mac_engine;
  localparam int W  = 32;
  localparam int CW = 16;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic signed [W-1:0] in_data = '0, mul_a, mul_p, out_data;
  logic signed [CW-1:0] mul_b;
  logic [2:0] out_index;
  logic s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 1;
  logic signed [11:0] s_in_data = '0, s_mul_a, s_mul_p, s_out_data;
  logic signed [CW-1:0] s_mul_b;
  logic [2:0] s_out_index;
  typedef struct {longint idx; longint data;} exp_t;
  exp_t sb[$];
  longint blk[8];
  longint first_data;
  int checks = 0, errors = 0, cyc = 0, last_acc = 0, last_out = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mul_p   = W'((longint'(mul_a) * longint'(mul_b)) >>> (CW - 1));
  assign s_mul_p = 12'((longint'(s_mul_a) * longint'(s_mul_b)) >>> (CW - 1));

  dct8_mac_engine #(.IN_W(W), .CONST_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index));

  dct8_mac_engine #(.IN_W(12), .CONST_W(CW)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_index(s_out_index));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrap(longint v, int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint cref(int k, int n);
    real a;
    a = 32767.0 * 0.5 * (k == 0 ? 1.0 / $sqrt(2.0) : 1.0) *
        $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
    return longint'($rtoi(a >= 0.0 ? a + 0.5 : a - 0.5));
  endfunction

  function automatic longint model(int k, int w);
    longint s, xv, mx;
    s = 0;
    for (int n = 0; n < 8; n++) begin
`ifdef DCT_LEVEL_SHIFT_EN
      xv = wrap(blk[n] - 128, w);
`else
      xv = wrap(blk[n], w);
`endif
      s += wrap((xv * cref(k, n)) >>> (CW - 1), w);
    end
    mx = (longint'(1) <<< (w - 1)) - 1;
    return s > mx ? mx : (s < -mx - 1 ? -mx - 1 : s);
  endfunction

  task automatic push_block();
    for (int k = 0; k < 8; k++) sb.push_back('{longint'(k), model(k, W)});
  endtask

  task automatic fill(input longint v);
    for (int n = 0; n < 8; n++) blk[n] = v;
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 8; n++) blk[n] = longint'($urandom_range(0, 200000)) - 100000;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_index"}, out_index, 0);
    chk({tag, "_mul_a"}, mul_a, 0);
    chk({tag, "_mul_b"}, mul_b, 0);
  endtask

  task automatic send(input bit rnd);
    int i, b;
    bit take;
    i = 0;
    b = 0;
    while (i < 8 && b < 300) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data = in_valid ? W'(blk[i]) : W'($urandom);
      chk("mul_a_load", mul_a, 0);
      chk("in_ready_load", in_ready, 1);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take) begin
        i++;
        last_acc = cyc;
      end
      b++;
    end
    in_valid = 0;
    chk("send_count", i, 8);
  endtask

  task automatic recv(input int cnt, input int stall_k, input bit junk);
    int b;
    exp_t e;
    logic signed [W-1:0] d;
    logic [2:0] ix;
    for (int j = 0; j < cnt; j++) begin
      b = 0;
      while (!out_valid && b < 40) begin
        in_valid = junk;
        in_data = W'($urandom);
        chk("in_ready_busy", in_ready, 0);
        @(posedge clk); #1;
        b++;
      end
      in_valid = 0;
      if (!out_valid) begin
        chk("out_timeout", out_valid, 1);
        return;
      end
      if (int'(out_index) == stall_k) begin
        out_ready = 0;
        d = out_data;
        ix = out_index;
        repeat (20) begin
          @(posedge clk); #1;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, d);
          chk("stall_index", out_index, ix);
          chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1;
      end
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() == 0) return;
      e = sb.pop_front();
      if (j == 0) first_data = out_data;
      chk("out_index", out_index, e.idx);
      chk("out_data", out_data, e.data);
      chk("mul_b_out", mul_b, 0);
      @(posedge clk); #1;
      last_out = cyc;
    end
  endtask

  initial begin
    int n_acc, b;
    bit take;
    #1;
    reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1;
    reset_outputs("rst_hold");
    rst_n = 1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);

    fill(100);
    send(0);
    push_block();
    recv(8, -1, 0);
    chk("latency_8_coeffs", last_out - last_acc, 72);
`ifndef DCT_LEVEL_SHIFT_EN
    chk("k0_of_100s", first_data, 280);
`endif

    fill(128);
    send(0);
    push_block();
    recv(8, -1, 0);

    fill_rand();
    send(1);
    push_block();
    recv(8, 3, 1);
    chk("sb_drained_stall", sb.size(), 0);

    fill_rand();
    send(0);
    push_block();
    recv(5, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    reset_outputs("mid_calc_rst");
    sb.delete();
    @(posedge clk); #1;
    chk("rst_no_output", out_valid, 0);
    rst_n = 1;
    @(posedge clk); #1;
    chk("in_ready_after_rst2", in_ready, 1);
    fill_rand();
    send(0);
    push_block();
    recv(8, -1, 0);
    chk("sb_drained_rst", sb.size(), 0);

    fill(2047);
    s_in_valid = 1;
    s_in_data = 12'sd2047;
    n_acc = 0;
    b = 0;
    while (n_acc < 8 && b < 100) begin
      take = s_in_valid && s_in_ready;
      @(posedge clk); #1;
      if (take) n_acc++;
      if (n_acc == 8) s_in_valid = 0;
      b++;
    end
    s_in_valid = 0;
    chk("sat_send_count", n_acc, 8);
    for (int k = 0; k < 8; k++) begin
      b = 0;
      while (!s_out_valid && b < 40) begin
        @(posedge clk); #1;
        b++;
      end
      chk("sat_out_valid", s_out_valid, 1);
      chk("sat_out_index", s_out_index, k);
      chk("sat_out_data", s_out_data, model(k, 12));
`ifndef DCT_LEVEL_SHIFT_EN
      if (k == 0) chk("sat_k0_2047", s_out_data, 2047);
`endif
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dct8_mac_engine.md
DCT8_MAC_ENGINE -- requirements
Module: dct8_mac_engine

Interface
REQ-001 SHALL have parameter IN_W, default 32: signed sample, product and result width.
REQ-002 SHALL have parameter CONST_W, default 16: signed coefficient width, Q(CONST_W-1) format.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: sample offered.
REQ-006 SHALL have port in_ready, output, 1: sample accepted when in_valid and in_ready are both high.
REQ-007 SHALL have port in_data, input, IN_W, signed: pixel sample x[n], n = 0..7 in arrival order.
REQ-008 SHALL have port mul_a, output, IN_W, signed: multiplicand to the external fixed-point multiplier.
REQ-009 SHALL have port mul_b, output, CONST_W, signed: cosine coefficient to the multiplier.
REQ-010 SHALL have port mul_p, input, IN_W, signed: the multiplier's (mul_a*mul_b)>>>(CONST_W-1) result, valid combinationally in the same cycle.
REQ-011 SHALL have port out_valid, output, 1: coefficient available.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the coefficient.
REQ-013 SHALL have port out_data, output, IN_W, signed: DCT coefficient X[k].
REQ-014 SHALL have port out_index, output, 3: the index k of out_data.

Function
REQ-015 SHALL implement the three-state FSM LOAD -> CALC -> OUT.
REQ-016 LOAD SHALL hold in_ready=1 and store each accepted sample into x[n], with n incrementing 0..7.
REQ-017 On acceptance of the 8th sample (n=7), the FSM SHALL go to CALC with k=0 and n=0.
REQ-018 In CALC, in_ready SHALL be 0.
REQ-019 In CALC, mul_a SHALL equal x[n] and mul_b SHALL equal C[k][n].
REQ-020 In CALC, the accumulator SHALL be acc += sign-extended mul_p, with acc width IN_W+3.
REQ-021 In CALC, n SHALL increment each cycle; acc SHALL be cleared at n=0 of every k.
REQ-022 After the n=7 cycle, the FSM SHALL go to OUT.
REQ-023 out_data SHALL be acc saturated to the signed IN_W range.
REQ-024 out_valid SHALL be 1 only in OUT, and out_data and out_index SHALL be held stable while out_ready=0.
REQ-025 On out_valid && out_ready with k<7, the FSM SHALL increment k and go to CALC.
REQ-026 On out_valid && out_ready with k=7, the FSM SHALL go to LOAD with n=0.
REQ-027 Latency SHALL be 8 CALC cycles plus at least 1 OUT cycle per coefficient, giving a minimum of 72 cycles from the 8th sample accepted to the 8th coefficient accepted.
REQ-028 C[k][n] SHALL be an internal constant ROM holding round((2^(CONST_W-1)-1) * 0.5 * c(k) * cos((2n+1)k*pi/16)), where c(0)=1/sqrt(2) and c(k>0)=1; for CONST_W=16, C[0][n]=11585.
REQ-029 When not in CALC, mul_a and mul_b SHALL be driven to 0.
REQ-030 in_valid arriving outside LOAD SHALL be ignored, with no sample captured.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in LOAD, n=0, k=0 and acc=0.
REQ-032 While rst_n=0, the outputs SHALL be in_ready=0, out_valid=0, out_data=0, out_index=0, mul_a=0 and mul_b=0.
REQ-033 One clock after rst_n deasserts, in_ready SHALL be 1.
REQ-034 Reset asserted mid-LOAD, mid-CALC or mid-OUT SHALL discard all partial samples and results, with no output produced.

Configuration
REQ-035 With macro DCT_LEVEL_SHIFT_EN defined, each sample SHALL be stored as in_data-128 (JPEG level shift), wrapping in IN_W.
REQ-036 Without DCT_LEVEL_SHIFT_EN, each sample SHALL be stored unmodified.
REQ-037 All other behaviour SHALL be identical with and without DCT_LEVEL_SHIFT_EN.

Verification
REQ-038 SHALL cover: IN_W=32, no shift, eight samples of 100, ideal multiplier model, out_ready=1 -> k=0 gives out_data=280, out_index=0, 72 cycles after the 8th accept.
REQ-039 SHALL cover: DCT_LEVEL_SHIFT_EN defined, eight samples of 128 -> all eight coefficients equal 0, out_index 0..7 in order.
REQ-040 SHALL cover: IN_W=12, eight samples of 2047 -> k=0 out_data=2047 (saturated, raw sum 5784).
REQ-041 SHALL cover: out_ready held 0 for 20 cycles at k=3 -> out_valid stays 1, out_data/out_index unchanged, in_ready=0, no k advance.
REQ-042 SHALL cover: rst_n pulsed low during CALC at k=5 -> outputs return to reset values immediately; next block of 8 samples produces a correct fresh k=0..7 sequence.
REQ-043 SHALL cover: in_valid toggled randomly during LOAD, plus in_valid=1 during CALC -> exactly 8 samples captured; CALC-time data ignored.
